// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

    // True when a load destination feeds one of the ID-stage sources; r0 never counts.
    function automatic logic dest_feeds_src(
        input logic [REG_ADDR_W-1:0] dest,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  uses_rt
    );
        return (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_load_use_detector.sv
// Load-use detector: flags an ID instruction that reads the register an EX-stage load is still fetching.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the top decides whether the hazard turns into a stall.
module load_use_detector
    import hazard_pkg::*;
(
    input  logic                  mem_read_EX,
    input  logic [REG_ADDR_W-1:0] write_addr_EX,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  uses_rt_ID,
    output logic                  hazard
);

    // rt only matters when the ID instruction really reads it (e.g. not for immediates).
    assign hazard = mem_read_EX && dest_feeds_src(write_addr_EX, rs_ID, rt_ID, uses_rt_ID);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: freeze on data-memory waits, flush on taken branches, one bubble per load-use hazard.
// Latency: stall/flush outputs are combinational from state and inputs (0 cycles); FSM, wait counter and perf counters update on clk.
// Backpressure: an unfinished MEM access freezes IF/ID/EX/MEM until mem_ready_MEM; HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_EX,
    input  logic [REG_ADDR_W-1:0] write_addr_EX,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  uses_rt_ID,
    input  logic                  branch_taken_EX,
    input  logic                  mem_req_MEM,
    input  logic                  mem_ready_MEM,
    output logic                  stall_IF,
    output logic                  stall_ID,
    output logic                  stall_EX,
    output logic                  stall_MEM,
    output logic                  flush_ID,
    output logic                  flush_EX,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    // wait_cnt only has to reach MEM_TIMEOUT-1; with the timeout disabled it simply wraps.
    localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze;
    logic              load_use;

    load_use_detector u_load_use (
        .mem_read_EX   (mem_read_EX),
        .write_addr_EX (write_addr_EX),
        .rs_ID         (rs_ID),
        .rt_ID         (rt_ID),
        .uses_rt_ID    (uses_rt_ID),
        .hazard        (load_use)
    );

    // Next state and freeze request; the release cycle of MEM_WAIT is not frozen.
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_req_MEM && !mem_ready_MEM) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_MEM) begin
                    state_nxt = RUN;
                end else begin
                    freeze = 1'b1;
                    if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        state_nxt = TIMEOUT;
                    end
                end
            end
            TIMEOUT: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Stall/flush priority: freeze, then branch flush (ID dies, so its hazard is moot), then load-use bubble.
    always_comb begin
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        stall_EX  = 1'b0;
        stall_MEM = 1'b0;
        flush_ID  = 1'b0;
        flush_EX  = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                stall_EX  = 1'b1;
                stall_MEM = 1'b1;
            end else if (branch_taken_EX) begin
                flush_ID = 1'b1;
                flush_EX = 1'b1;
            end else if (load_use) begin
                stall_IF = 1'b1;
                stall_ID = 1'b1;
                flush_EX = 1'b1;
            end
        end
    end

    // State register, MEM_WAIT dwell counter and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == MEM_WAIT) && (state_nxt == MEM_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state_nxt == TIMEOUT) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             branch_flush;

    assign branch_flush = !rst && !freeze && branch_taken_EX;

    // Saturating counters of front-end stall cycles and branch-flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_IF && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (branch_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: one instance with MEM_TIMEOUT=4, one with the timeout disabled and 2-bit counters.
// Latency: outputs sampled on the falling edge of the cycle whose inputs were driven after the rising edge.
// Backpressure: expected outputs queue up per driven step and are popped when the outputs are sampled.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read_EX;
    logic [4:0] write_addr_EX;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic       uses_rt_ID;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ready_MEM;

    logic        stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, mem_timeout;
    logic [31:0] stall_cycles, flush_count;
    logic        s_stall_IF, s_stall_ID, s_stall_EX, s_stall_MEM, s_flush_ID, s_flush_EX, s_mem_timeout;
    logic [1:0]  s_stall_cycles, s_flush_count;

    logic [6:0] got;
    logic [6:0] got_sat;
    assign got     = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, mem_timeout};
    assign got_sat = {s_stall_IF, s_stall_ID, s_stall_EX, s_stall_MEM, s_flush_ID, s_flush_EX, s_mem_timeout};

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read_EX(mem_read_EX), .write_addr_EX(write_addr_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
        .flush_ID(flush_ID), .flush_EX(flush_EX), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_control_unit #(.MEM_TIMEOUT(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mem_read_EX(mem_read_EX), .write_addr_EX(write_addr_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID), .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
        .stall_IF(s_stall_IF), .stall_ID(s_stall_ID), .stall_EX(s_stall_EX), .stall_MEM(s_stall_MEM),
        .flush_ID(s_flush_ID), .flush_EX(s_flush_EX), .mem_timeout(s_mem_timeout),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    // Output vector: {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, mem_timeout}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] FRZ  = 7'b1111000;
    localparam logic [6:0] TO   = 7'b1111001;
    localparam logic [6:0] MTO  = 7'b0000001;

    typedef struct packed {
        logic       rst, mr;
        logic [4:0] wa, rs, rt;
        logic       urt, br, req, rdy;
        logic [6:0] exp, exp_sat;
    } step_t;

    typedef struct packed {
        logic [6:0] a, b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Counter model: counts through all steps applied so far; snap_* holds counts before the latest step.
    int mdl_stall = 0, mdl_flush = 0, mdl_stall_s = 0, mdl_flush_s = 0;
    int snap_stall = 0, snap_flush = 0, snap_stall_s = 0, snap_flush_s = 0;

    function automatic step_t ss(input logic r, input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urt, input logic br, input logic req,
                                 input logic rdy, input logic [6:0] e, input logic [6:0] es);
        step_t st;
        st.rst = r; st.mr = mr; st.wa = wa; st.rs = rs; st.rt = rt;
        st.urt = urt; st.br = br; st.req = req; st.rdy = rdy; st.exp = e; st.exp_sat = es;
        return st;
    endfunction

    function automatic step_t s(input logic r, input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urt, input logic br, input logic req,
                                input logic rdy, input logic [6:0] e);
        return ss(r, mr, wa, rs, rt, urt, br, req, rdy, e, e);
    endfunction

    task automatic apply(input step_t st);
        exp_t e;
        @(posedge clk);
        #1;
        rst = st.rst; mem_read_EX = st.mr; write_addr_EX = st.wa; rs_ID = st.rs; rt_ID = st.rt;
        uses_rt_ID = st.urt; branch_taken_EX = st.br; mem_req_MEM = st.req; mem_ready_MEM = st.rdy;
        e.a = st.exp;
        e.b = st.exp_sat;
        exp_q.push_back(e);
        snap_stall = mdl_stall; snap_flush = mdl_flush; snap_stall_s = mdl_stall_s; snap_flush_s = mdl_flush_s;
        if (st.rst) begin
            mdl_stall = 0; mdl_flush = 0; mdl_stall_s = 0; mdl_flush_s = 0;
        end else begin
            mdl_stall   += int'(st.exp[6]);
            mdl_flush   += int'(st.exp[2]);
            mdl_stall_s += int'(st.exp_sat[6]);
            mdl_flush_s += int'(st.exp_sat[2]);
        end
    endtask

    task automatic test_reset();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(s(1, 1, 5, 5, 0, 0, 1, 1, 0, NONE));
        tbl.push_back(s(1, 1, 5, 5, 0, 0, 1, 1, 0, NONE));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL reset[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL reset_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
        n_cmp++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            n_err++; $display("FAIL reset_counters stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
        end
    endtask

    task automatic test_load_use();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(s(0, 1, 5, 5, 2, 1, 0, 0, 0, LU));    // load r5, ID rs=r5
        tbl.push_back(s(0, 0, 0, 5, 2, 1, 0, 0, 0, NONE));  // load moved to MEM
        tbl.push_back(s(0, 1, 9, 3, 9, 1, 0, 0, 0, LU));    // rt match, rt used
        tbl.push_back(s(0, 1, 3, 3, 4, 0, 0, 0, 0, LU));    // back-to-back hazard, new load
        tbl.push_back(s(0, 1, 6, 5, 7, 1, 0, 0, 0, NONE));  // no match
        tbl.push_back(s(0, 1, 0, 0, 0, 1, 0, 0, 0, NONE));  // r0 never hazards
        tbl.push_back(s(0, 1, 7, 2, 7, 0, 0, 0, 0, NONE));  // rt match but rt unused
        tbl.push_back(s(0, 0, 5, 5, 5, 1, 0, 0, 0, NONE));  // not a load
        tbl.push_back(s(0, 1, 31, 31, 0, 0, 0, 0, 0, LU));  // highest register
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL load_use[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL load_use_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
    endtask

    task automatic test_branch();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(s(0, 1, 5, 5, 0, 0, 1, 0, 0, BR));    // branch beats load-use
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, 0, 0, BR));    // plain branch
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL branch[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL branch_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
    endtask

    task automatic test_mem_wait();
        step_t tbl[$];
        exp_t  e;
        for (int k = 0; k < 3; k++) tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE));  // release cycle
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));  // back in RUN
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 1, NONE));  // stray ready ignored
        for (int k = 0; k < 3; k++) tbl.push_back(s(0, 1, 5, 5, 0, 0, 1, 1, 0, FRZ));
        tbl.push_back(s(0, 1, 5, 5, 0, 0, 1, 1, 1, BR));    // held branch flushes on release
        for (int k = 0; k < 3; k++) tbl.push_back(s(0, 1, 4, 4, 0, 0, 0, 1, 0, FRZ));
        tbl.push_back(s(0, 1, 4, 4, 0, 0, 0, 1, 1, LU));    // load-use resolved on release
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL mem_wait[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL mem_wait_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
    endtask

    task automatic test_timeout();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));                 // RUN -> MEM_WAIT
        for (int k = 0; k < 4; k++) tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));  // 4 wait cycles
        tbl.push_back(ss(0, 0, 0, 0, 0, 0, 0, 1, 0, TO, FRZ));           // timed out; disabled copy waits on
        tbl.push_back(ss(0, 0, 0, 0, 0, 0, 0, 1, 1, TO, NONE));          // ready no longer rescues it
        tbl.push_back(ss(1, 0, 0, 0, 0, 0, 0, 1, 0, MTO, NONE));         // rst: stalls drop, flag still held
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        tbl.push_back(s(1, 0, 0, 0, 0, 0, 0, 1, 0, NONE));               // reset mid-wait
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));               // RUN again
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL timeout[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL timeout_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
    endtask

    task automatic test_perf();
        step_t tbl[$];
        exp_t  e;
        int    w_sc, w_fc, w_ssc, w_sfc;
        tbl.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        tbl.push_back(s(0, 1, 5, 5, 0, 0, 0, 0, 0, LU));
        tbl.push_back(s(0, 0, 0, 5, 0, 0, 0, 0, 0, NONE));
        for (int k = 0; k < 3; k++) tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 1, 1, 1, BR));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));   // counters now 4 / 1
        tbl.push_back(s(0, 1, 8, 8, 0, 0, 0, 0, 0, LU));
        tbl.push_back(s(0, 1, 8, 1, 8, 1, 0, 0, 0, LU));
        tbl.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));   // counters now 6 / 1, saturated copy 3 / 1
        foreach (tbl[i]) begin
            apply(tbl[i]);
`ifdef HAZARD_PERF_CNT_EN
            w_sc  = snap_stall;
            w_fc  = snap_flush;
            w_ssc = (snap_stall_s > 3) ? 3 : snap_stall_s;
            w_sfc = (snap_flush_s > 3) ? 3 : snap_flush_s;
`else
            w_sc = 0; w_fc = 0; w_ssc = 0; w_sfc = 0;
`endif
            n_cmp++;
            if (stall_cycles !== 32'(w_sc)) begin n_err++; $display("FAIL stall_cycles[%0d] got=%0d want=%0d", i, stall_cycles, w_sc); end
            n_cmp++;
            if (flush_count !== 32'(w_fc)) begin n_err++; $display("FAIL flush_count[%0d] got=%0d want=%0d", i, flush_count, w_fc); end
            n_cmp++;
            if (s_stall_cycles !== 2'(w_ssc)) begin n_err++; $display("FAIL sat_stall_cycles[%0d] got=%0d want=%0d", i, s_stall_cycles, w_ssc); end
            n_cmp++;
            if (s_flush_count !== 2'(w_sfc)) begin n_err++; $display("FAIL sat_flush_count[%0d] got=%0d want=%0d", i, s_flush_count, w_sfc); end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e.a) begin n_err++; $display("FAIL perf[%0d] outs=%b want=%b", i, got, e.a); end
            n_cmp++;
            if (got_sat !== e.b) begin n_err++; $display("FAIL perf_sat[%0d] outs=%b want=%b", i, got_sat, e.b); end
        end
    endtask

    initial begin
        rst = 1'b1; mem_read_EX = 1'b0; write_addr_EX = '0; rs_ID = '0; rt_ID = '0;
        uses_rt_ID = 1'b0; branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready_MEM = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

endmodule
